// File: rtl/simple_fifo.sv
// Single-clock show-ahead FIFO with full/empty status.
// Define SIMPLE_FIFO_ERR_EN for sticky overflow/underflow flags.
module simple_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
`ifdef SIMPLE_FIFO_ERR_EN
  output logic              empty,
  output logic              overflow,
  output logic              underflow
`else
  output logic              empty
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] data [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // a pop in the same cycle frees the slot a full push needs
  assign push_ok  = push && (!full || pop_ok);
  assign data_out = data[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) data[wr_ptr] <= data_in;
  end

`ifdef SIMPLE_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop_ok) overflow <= 1'b1;
      if (pop && empty)            underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_simple_fifo.sv
// Directed self-checking bench for simple_fifo.
// Hand-computed vectors: reset, wrap, overflow, simultaneous ops.
module tb_simple_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic        pop;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        full;
  logic        empty;
`ifdef SIMPLE_FIFO_ERR_EN
  logic        overflow;
  logic        underflow;
`endif

  int checks = 0;
  int failures = 0;

  simple_fifo #(.DATA_W(16), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
`ifdef SIMPLE_FIFO_ERR_EN
    .empty    (empty),
    .overflow (overflow),
    .underflow(underflow)
`else
    .empty    (empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] v);
    push = 1'b1;
    data_in = v;
    step();
    push = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] v);
    chk(tag, data_out, v);
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic fill_drain(input logic [15:0] a,
                            input logic [15:0] b,
                            input int idle);
    for (int i = 0; i < idle; i++) step();
    for (int i = 0; i < 8; i++) push_word((i % 2 == 0) ? a : b);
    chk("fd_full", full, 1);
    chk("fd_notempty", empty, 0);
    for (int i = 0; i < 8; i++)
      pop_expect("fd_data", (i % 2 == 0) ? a : b);
    chk("fd_empty", empty, 1);
    chk("fd_notfull", full, 0);
  endtask

  initial begin
    reset = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    data_in = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("pop_on_empty", empty, 1);
`ifdef SIMPLE_FIFO_ERR_EN
    chk("underflow_set", underflow, 1);
    chk("overflow_clear", overflow, 0);
`endif

    fill_drain(16'hFFFF, 16'h0000, 0);
    fill_drain(16'h1234, 16'hEDCB, 5);
    fill_drain(16'h1234, 16'hEDCB, 4);
    fill_drain(16'h1234, 16'hEDCB, 6);

    for (int i = 0; i < 8; i++) push_word(16'h0100 + 16'(i));
    push_word(16'hAAAA);
    chk("ovf_full", full, 1);
`ifdef SIMPLE_FIFO_ERR_EN
    chk("overflow_set", overflow, 1);
`endif
    for (int i = 0; i < 8; i++) pop_expect("ovf_data", 16'h0100 + 16'(i));
    chk("ovf_empty", empty, 1);

    for (int i = 0; i < 3; i++) push_word(16'h0010 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      chk("sim_head", data_out, 16'h0010 + 16'(i));
      push = 1'b1;
      pop = 1'b1;
      data_in = 16'h0013 + 16'(i);
      step();
    end
    push = 1'b0;
    pop = 1'b0;
    chk("sim_notempty", empty, 0);
    chk("sim_notfull", full, 0);
    for (int i = 0; i < 3; i++) pop_expect("sim_data", 16'h0014 + 16'(i));
    chk("sim_empty", empty, 1);

    for (int i = 0; i < 8; i++) push_word(16'h0020 + 16'(i));
    chk("fsim_head", data_out, 16'h0020);
    push = 1'b1;
    pop = 1'b1;
    data_in = 16'h0028;
    step();
    push = 1'b0;
    pop = 1'b0;
    chk("fsim_full", full, 1);
    for (int i = 0; i < 8; i++) pop_expect("fsim_data", 16'h0021 + 16'(i));
    chk("fsim_empty", empty, 1);

    for (int i = 0; i < 5; i++) push_word(16'h0050 + 16'(i));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
`ifdef SIMPLE_FIFO_ERR_EN
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
`endif
    push_word(16'h0042);
    chk("post_rst_data", data_out, 16'h0042);
    chk("post_rst_notempty", empty, 0);
    pop_expect("post_rst_pop", 16'h0042);
    chk("post_rst_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_fifo.md
Name: simple_fifo

Overview:
Synchronous single-clock FIFO with first-word-fall-through (show-ahead) read.
- Buffers DATA_W-bit words between a producer (push) and a consumer (pop) in the same clock domain.
- Reports full/empty status.
- Used as a small elastic buffer and as a reference block for bench and waveform flows.

Parameters:
DATA_W, 16, word width in bits.
DEPTH, 8, number of entries; must be a power of two, at least 2.
ADDR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
clk  input  1  rising-edge clock for all state.
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
push  input  1  write request; data_in is written on the rising edge when accepted.
pop  input  1  read request; the head entry is discarded on the rising edge when accepted.
data_in  input  DATA_W  write data.
data_out  output  DATA_W  current head of queue (oldest entry), combinational from storage.
full  output  1  high when DEPTH entries are held.
empty  output  1  high when 0 entries are held.

Behaviour:
Reset and interface:
- Single clock domain. Reset is synchronous and active-high.
- reset=1 at a rising edge: write pointer, read pointer and occupancy count go to 0; empty=1, full=0.
- Reset takes priority over push/pop in the same cycle. Reset mid-operation discards all contents.
- Storage array is named data[0..DEPTH-1] (probed by benches) and is not reset.
- data_out is undefined while empty.

Status and read data:
- full and empty are decoded from the registered occupancy count (0..DEPTH, ADDR_W+1 bits). They are valid in the cycle after the edge that changed the count.
- data_out = data[rd_ptr], continuously. The oldest word is visible before and during the pop cycle (zero read latency).

Push and pop acceptance:
- push accepted when push=1 and (full=0 or pop accepted in the same cycle).
  On acceptance: data[wr_ptr] <= data_in and wr_ptr increments modulo DEPTH.
- pop accepted when pop=1 and empty=0.
  On acceptance: rd_ptr increments modulo DEPTH; data_out shows the next entry after the edge.
- Push while full (no pop): ignored; data and pointers are unchanged.
- Pop while empty: ignored; a simultaneous push is still accepted.
- Push and pop while neither full nor empty: both are accepted and the count is unchanged.
- Push and pop while full: both are accepted, the count stays at DEPTH, and full stays 1.
- Pointers wrap freely.
  - The FIFO must operate correctly for any fill/drain sequence regardless of pointer phase.
  - Example: fill 8, drain 8, idle any number of cycles (odd or even), fill 8, drain 8.
- Ordering: strict first-in first-out. A single push/pop pulse moves exactly one word.

Optional Feature:
Macro SIMPLE_FIFO_ERR_EN.
- When defined, adds two outputs, overflow (1 bit) and underflow (1 bit). Both are sticky error flags cleared only by reset.
  - overflow sets on the edge where push=1, full=1 and pop is not accepted.
  - underflow sets on the edge where pop=1 and empty=1.
  - Ignored operations otherwise behave exactly as in the base design.
- When not defined, these ports and their logic are absent and the port list is exactly as above.

Test Plan:
1. Reset: hold reset=1 for 2 edges, then release -> empty=1, full=0; a pop with no pushes leaves empty=1.
2. Fill/drain: push 8 words alternating 16'hFFFF, 16'h0000, ... -> full=1, empty=0. Then pop 8 times, checking data_out before each pop edge -> FFFF, 0000, FFFF, ... Afterwards empty=1, full=0.
3. Wrap: after scenario 2, idle 5 cycles and repeat with 16'h1234 / 16'hEDCB. Repeat again with 4 and 6 idle cycles -> correct order every time, full/empty correct.
4. Overflow ignore: fill 8, push 16'hAAAA -> full stays 1; draining returns the original 8 words only. With SIMPLE_FIFO_ERR_EN defined, overflow=1 until reset.
5. Simultaneous: with 3 entries, push+pop for 4 cycles -> count stays 3 and pops return the oldest words in order. When full, push+pop -> full stays 1 and the newest word appears last.
6. Reset mid-operation: push 5 words, assert reset for 1 edge -> empty=1. Then push 16'h0042 -> data_out=16'h0042, no stale data.
